// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin, burst-limited sharing of one BRAM port between two masters
// Ports: CLK/RST_N clock and sync active-low reset; req_x/addr_x/din_x/we_x master requests;
//        gnt_x port ownership; rvalid_x/rdata tagged read return; bram_* shared BRAM port;
//        sel current or last owner for the downstream mux.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 1,
  parameter int BURST_MAX  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [31:0]           din_0,
  input  logic [31:0]           din_1,
  input  logic                  we_0,
  input  logic                  we_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic [31:0]           rdata,
  input  logic [31:0]           bram_dout,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [31:0]           bram_din_out,
  output logic                  bram_en_out,
  output logic                  bram_we_out,
  output logic                  sel
);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t                state;
  logic                  last_owner;
  logic                  sel_r;
  logic [BW-1:0]         bcnt;
  logic [RD_LATENCY-1:0] pv;
  logic [RD_LATENCY-1:0] po;
  logic                  own;
  logic                  req_own;
  logic                  req_oth;
  logic                  take;
  logic                  at_lim;
  logic                  pick;
  always_comb begin
    gnt_0         = state == GNT0;
    gnt_1         = state == GNT1;
    own           = gnt_1;
    req_own       = own ? req_1 : req_0;
    req_oth       = own ? req_0 : req_1;
    take          = (gnt_0 & req_0) | (gnt_1 & req_1);
    bram_en_out   = take;
    bram_we_out   = take & (own ? we_1 : we_0);
    bram_addr_out = own ? addr_1 : addr_0;
    bram_din_out  = own ? din_1 : din_0;
    at_lim        = bcnt >= BW'(BURST_MAX - 1);
    pick          = (req_0 & req_1) ? ~last_owner : req_1;
    sel           = sel_r;
    rdata         = bram_dout;
    rvalid_0      = pv[RD_LATENCY-1] & ~po[RD_LATENCY-1];
    rvalid_1      = pv[RD_LATENCY-1] & po[RD_LATENCY-1];
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      sel_r      <= 1'b0;
      bcnt       <= '0;
      pv         <= '0;
      po         <= '0;
    end else begin
      // read tags shift toward the output; the low bit takes this cycle's access
      pv <= RD_LATENCY'({pv, take & ~bram_we_out});
      po <= RD_LATENCY'({po, own});
      if (state == IDLE) begin
        if (req_0 | req_1) begin
          state      <= pick ? GNT1 : GNT0;
          last_owner <= pick;
          sel_r      <= pick;
          bcnt       <= '0;
        end
      end else begin
        if (take)
          bcnt <= at_lim ? BW'(BURST_MAX) : bcnt + 1'b1;
        // at_lim covers both reaching the limit now and already sitting at it
        if (!req_own || (req_oth && at_lim))
          state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;
  logic        CLK;
  logic        RST_N;
  logic        req_0, req_1, we_0, we_1;
  logic [10:0] addr_0, addr_1;
  logic [31:0] din_0, din_1, bram_dout;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0] rdata, bram_din_out;
  logic [10:0] bram_addr_out;
  logic        bram_en_out, bram_we_out, sel;
  int          n_cmp = 0;
  int          n_err = 0;
  bram_port_arbiter #(.ADDR_WIDTH(11), .RD_LATENCY(3), .BURST_MAX(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_0(req_0), .req_1(req_1), .addr_0(addr_0), .addr_1(addr_1),
    .din_0(din_0), .din_1(din_1), .we_0(we_0), .we_1(we_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata(rdata), .bram_dout(bram_dout), .bram_addr_out(bram_addr_out),
    .bram_din_out(bram_din_out), .bram_en_out(bram_en_out),
    .bram_we_out(bram_we_out), .sel(sel)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask
  task automatic gnt(input string tag, input logic g0, input logic g1, input logic en);
    chk({tag, "_gnt0"}, gnt_0, g0);
    chk({tag, "_gnt1"}, gnt_1, g1);
    chk({tag, "_en"}, bram_en_out, en);
  endtask
  task automatic rv(input string tag, input logic r0, input logic r1);
    chk({tag, "_rv0"}, rvalid_0, r0);
    chk({tag, "_rv1"}, rvalid_1, r1);
  endtask
  initial begin
    RST_N = 0; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
    addr_0 = 0; addr_1 = 0; din_0 = 0; din_1 = 0; bram_dout = 0;
    repeat (2) @(posedge CLK);
    #1;
    #1;
    gnt("rst", 0, 0, 0);
    rv("rst", 0, 0);
    chk("rst_sel", sel, 0);
    chk("rst_we", bram_we_out, 0);
    RST_N = 1; req_0 = 1; addr_0 = 11'h10; #1;
    gnt("t1_idle", 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      req_0 = k <= 4;
      addr_0 = 11'h10 + 11'(k - 1);
      bram_dout = 32'hD000_0000 + 32'(k);
      #1;
      gnt("t1", k <= 5, 0, k <= 4);
      if (k <= 4) chk("t1_addr", bram_addr_out, 32'h10 + 32'(k - 1));
      rv("t1", k >= 4 && k <= 7, 0);
      chk("t1_rdata", rdata, 32'hD000_0000 + 32'(k));
      chk("t1_sel", sel, 0);
    end
    nxt(); RST_N = 0; #1;
    nxt(); RST_N = 1; req_0 = 1; req_1 = 1; addr_0 = 11'h5; addr_1 = 11'h6; #1;
    gnt("t2_idle", 0, 0, 0);
    chk("t2_sel0", sel, 0);
    nxt(); #1;
    gnt("t2_tie", 1, 0, 1);
    chk("t2_addr0", bram_addr_out, 32'h5);
    nxt(); req_0 = 0; #1;
    gnt("t2_rel", 1, 0, 0);
    nxt(); #1;
    gnt("t2_dead", 0, 0, 0);
    chk("t2_dead_sel", sel, 0);
    nxt(); #1;
    gnt("t2_g1", 0, 1, 1);
    chk("t2_sel1", sel, 1);
    chk("t2_addr1", bram_addr_out, 32'h6);
    rv("t2_ret0", 1, 0);
    nxt(); req_1 = 0; #1;
    gnt("t2_rel1", 0, 1, 0);
    rv("t2_gap", 0, 0);
    nxt(); #1;
    gnt("t2_idle2", 0, 0, 0);
    chk("t2_hold_sel", sel, 1);
    nxt(); #1;
    rv("t2_ret1", 0, 1);
    nxt(); req_1 = 1; we_1 = 1; #1;
    gnt("t3_idle", 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      if (k == 2) req_0 = 1;
      addr_1 = 11'h100 + 11'(k);
      din_1 = 32'h5500_0000 + 32'(k);
      #1;
      gnt("t3_burst", 0, 1, 1);
      chk("t3_we", bram_we_out, 1);
      chk("t3_addr", bram_addr_out, 32'h100 + 32'(k));
      chk("t3_din", bram_din_out, 32'h5500_0000 + 32'(k));
      rv("t3", 0, 0);
    end
    nxt(); we_0 = 1; #1;
    gnt("t3_dead", 0, 0, 0);
    chk("t3_dead_we", bram_we_out, 0);
    for (int k = 1; k <= 40; k++) begin
      nxt();
      if (k == 1) req_1 = 0;
      addr_0 = 11'(k);
      din_0 = 32'hA500 + 32'(k);
      #1;
      gnt("t4_stream", 1, 0, 1);
      chk("t4_we", bram_we_out, 1);
      chk("t4_din", bram_din_out, 32'hA500 + 32'(k));
      rv("t4", 0, 0);
    end
    nxt(); req_1 = 1; #1;
    gnt("t4_contend", 1, 0, 1);
    nxt(); req_0 = 0; req_1 = 0; we_0 = 0; #1;
    gnt("t4_drop", 0, 0, 0);
    chk("t4_sel", sel, 0);
    nxt(); req_0 = 1; addr_0 = 11'h7FF; #1;
    gnt("t5_idle", 0, 0, 0);
    nxt(); #1;
    gnt("t5_a0", 1, 0, 1);
    chk("t5_addr0", bram_addr_out, 32'h7FF);
    chk("t5_we0", bram_we_out, 0);
    nxt(); req_0 = 0; req_1 = 1; addr_1 = 11'h000; we_1 = 0; #1;
    gnt("t5_rel", 1, 0, 0);
    nxt(); #1;
    gnt("t5_dead", 0, 0, 0);
    rv("t5_dead", 0, 0);
    nxt(); bram_dout = 32'hCAFE_07FF; #1;
    gnt("t5_a1", 0, 1, 1);
    chk("t5_addr1", bram_addr_out, 32'h0);
    chk("t5_sel", sel, 1);
    rv("t5_ret0", 1, 0);
    chk("t5_rdata0", rdata, 32'hCAFE_07FF);
    nxt(); req_1 = 0; bram_dout = 0; #1;
    rv("t5_gap1", 0, 0);
    nxt(); #1;
    rv("t5_gap2", 0, 0);
    nxt(); bram_dout = 32'hBEEF_0000; #1;
    rv("t5_ret1", 0, 1);
    chk("t5_rdata1", rdata, 32'hBEEF_0000);
    nxt(); #1;
    rv("t5_after", 0, 0);
    nxt(); req_0 = 1; addr_0 = 11'h20; #1;
    nxt(); #1;
    gnt("t6_a", 1, 0, 1);
    nxt(); addr_0 = 11'h21; #1;
    gnt("t6_b", 1, 0, 1);
    nxt(); RST_N = 0; #1;
    nxt(); RST_N = 1; #1;
    gnt("t6_rst", 0, 0, 0);
    rv("t6_rst", 0, 0);
    chk("t6_sel", sel, 0);
    chk("t6_we", bram_we_out, 0);
    nxt(); #1;
    gnt("t6_regnt", 1, 0, 1);
    rv("t6_drop1", 0, 0);
    nxt(); req_0 = 0; #1;
    rv("t6_drop2", 0, 0);
    nxt(); #1;
    rv("t6_drop3", 0, 0);
    nxt(); #1;
    rv("t6_new", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
